// File: rtl/axi_uart_regs.sv
// AXI4 slave register front-end for a UART: DATA/STATUS decode with TX and RX byte FIFOs.
// Optional sticky RX overrun flag in STATUS bit2, enabled by defining UART_OVERRUN_EN.
module axi_uart_regs #(
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16,
    parameter int ID_W     = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [ID_W-1:0] ar_id,
    input  logic [31:0]     ar_addr,
    input  logic [7:0]      ar_len,
    input  logic [2:0]      ar_size,
    input  logic [1:0]      ar_burst,
    input  logic            ar_valid,
    output logic            ar_ready,
    output logic [ID_W-1:0] r_id,
    output logic [31:0]     r_data,
    output logic [1:0]      r_resp,
    output logic            r_last,
    output logic            r_valid,
    input  logic            r_ready,
    input  logic [ID_W-1:0] aw_id,
    input  logic [31:0]     aw_addr,
    input  logic [7:0]      aw_len,
    input  logic [2:0]      aw_size,
    input  logic [1:0]      aw_burst,
    input  logic            aw_valid,
    output logic            aw_ready,
    input  logic [31:0]     w_data,
    input  logic [3:0]      w_strb,
    input  logic            w_last,
    input  logic            w_valid,
    output logic            w_ready,
    output logic [ID_W-1:0] b_id,
    output logic [1:0]      b_resp,
    output logic            b_valid,
    input  logic            b_ready,
    output logic [7:0]      tx_data,
    output logic            tx_valid,
    input  logic            tx_ready,
    input  logic [7:0]      rx_data,
    input  logic            rx_valid
);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam logic [TX_AW:0] TX_FULL_CNT = TX_DEPTH[TX_AW:0];
    localparam logic [RX_AW:0] RX_FULL_CNT = RX_DEPTH[RX_AW:0];

    typedef enum logic [1:0] {R_IDLE, R_LOAD, R_DATA} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

    logic [7:0]       tx_mem [TX_DEPTH];
    logic [7:0]       rx_mem [RX_DEPTH];
    logic [TX_AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [RX_AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [TX_AW:0]   tx_cnt_q, tx_cnt_d;
    logic [RX_AW:0]   rx_cnt_q, rx_cnt_d;
    logic             tx_push, tx_pop, tx_full, tx_empty;
    logic             rx_push, rx_pop, rx_full, rx_empty, rx_drop;

    r_state_e         r_state_q;
    w_state_e         w_state_q;
    logic             ar_ready_q, r_valid_q, r_last_q, r_stat_q, pop_pending_q;
    logic [31:0]      r_data_q;
    logic [ID_W-1:0]  r_id_q, b_id_q;
    logic [7:0]       r_len_q, r_cnt_q;
    logic             aw_ready_q, b_valid_q, w_stat_q;
    logic             overrun, stat_rd_hs;
    logic [31:0]      status_word;

    assign tx_full  = (tx_cnt_q == TX_FULL_CNT);
    assign tx_empty = (tx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == RX_FULL_CNT);
    assign rx_empty = (rx_cnt_q == '0);

    assign w_ready  = (w_state_q == W_DATA) && (w_stat_q || !tx_full);
    assign tx_push  = w_ready && w_valid && !w_stat_q && w_strb[0];
    assign tx_valid = !tx_empty;
    assign tx_data  = tx_mem[tx_rp_q];
    assign tx_pop   = tx_valid && tx_ready;

    // A full RX FIFO still accepts a byte when the read side frees a slot in the same cycle.
    assign rx_pop   = (r_state_q == R_DATA) && r_ready && pop_pending_q;
    assign rx_push  = rx_valid && (!rx_full || rx_pop);
    assign rx_drop  = rx_valid && rx_full && !rx_pop;

    assign stat_rd_hs  = (r_state_q == R_DATA) && r_ready && r_stat_q;
    assign status_word = {29'b0, overrun, !rx_empty, !tx_full};

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        tx_wp_d  = tx_wp_q;
        tx_rp_d  = tx_rp_q;
        rx_wp_d  = rx_wp_q;
        rx_rp_d  = rx_rp_q;
        if (tx_push) tx_wp_d = tx_wp_q + 1'b1;
        if (tx_pop)  tx_rp_d = tx_rp_q + 1'b1;
        if (rx_push) rx_wp_d = rx_wp_q + 1'b1;
        if (rx_pop)  rx_rp_d = rx_rp_q + 1'b1;
        tx_cnt_d = tx_cnt_q + {{TX_AW{1'b0}}, tx_push} - {{TX_AW{1'b0}}, tx_pop};
        rx_cnt_d = rx_cnt_q + {{RX_AW{1'b0}}, rx_push} - {{RX_AW{1'b0}}, rx_pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            tx_cnt_q <= '0;
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            tx_wp_q  <= tx_wp_d;
            tx_rp_q  <= tx_rp_d;
            tx_cnt_q <= tx_cnt_d;
            rx_wp_q  <= rx_wp_d;
            rx_rp_q  <= rx_rp_d;
            rx_cnt_q <= rx_cnt_d;
        end
    end

    // NOTE: FIFO storage is not reset; the counts and pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp_q] <= w_data[7:0];
        if (rx_push) rx_mem[rx_wp_q] <= rx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q     <= R_IDLE;
            ar_ready_q    <= 1'b1;
            r_valid_q     <= 1'b0;
            r_last_q      <= 1'b0;
            r_data_q      <= '0;
            r_id_q        <= '0;
            r_len_q       <= '0;
            r_cnt_q       <= '0;
            r_stat_q      <= 1'b0;
            pop_pending_q <= 1'b0;
        end else begin
            case (r_state_q)
                R_IDLE: if (ar_valid) begin
                    ar_ready_q <= 1'b0;
                    r_id_q     <= ar_id;
                    r_len_q    <= ar_len;
                    r_stat_q   <= ar_addr[2];
                    r_cnt_q    <= '0;
                    r_state_q  <= R_LOAD;
                end
                R_LOAD: begin
                    r_data_q      <= r_stat_q ? status_word : (rx_empty ? 32'h0 : {24'h0, rx_mem[rx_rp_q]});
                    pop_pending_q <= !r_stat_q && !rx_empty;
                    r_last_q      <= (r_cnt_q == r_len_q);
                    r_valid_q     <= 1'b1;
                    r_state_q     <= R_DATA;
                end
                R_DATA: if (r_ready) begin
                    r_valid_q     <= 1'b0;
                    pop_pending_q <= 1'b0;
                    r_cnt_q       <= r_cnt_q + 8'd1;
                    if (r_last_q) begin
                        r_last_q   <= 1'b0;
                        ar_ready_q <= 1'b1;
                        r_state_q  <= R_IDLE;
                    end else begin
                        r_state_q  <= R_LOAD;
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q  <= W_IDLE;
            aw_ready_q <= 1'b1;
            b_valid_q  <= 1'b0;
            b_id_q     <= '0;
            w_stat_q   <= 1'b0;
        end else begin
            case (w_state_q)
                W_IDLE: if (aw_valid) begin
                    aw_ready_q <= 1'b0;
                    b_id_q     <= aw_id;
                    w_stat_q   <= aw_addr[2];
                    w_state_q  <= W_DATA;
                end
                W_DATA: if (w_valid && w_ready && w_last) begin
                    b_valid_q <= 1'b1;
                    w_state_q <= W_RESP;
                end
                W_RESP: if (b_ready) begin
                    b_valid_q  <= 1'b0;
                    aw_ready_q <= 1'b1;
                    w_state_q  <= W_IDLE;
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

`ifdef UART_OVERRUN_EN
    logic overrun_q, overrun_d;

    // Set wins over clear so a drop coincident with a STATUS read is never lost.
    always_comb begin
        overrun_d = overrun_q;
        if (stat_rd_hs) overrun_d = 1'b0;
        if (rx_drop)    overrun_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) overrun_q <= 1'b0;
        else        overrun_q <= overrun_d;
    end

    assign overrun = overrun_q;
`else
    logic unused_ovf;
    assign unused_ovf = rx_drop ^ stat_rd_hs;
    assign overrun    = 1'b0;
`endif

    assign ar_ready = ar_ready_q;
    assign r_valid  = r_valid_q;
    assign r_last   = r_last_q;
    assign r_data   = r_data_q;
    assign r_id     = r_id_q;
    assign r_resp   = 2'b00;
    assign aw_ready = aw_ready_q;
    assign b_valid  = b_valid_q;
    assign b_id     = b_id_q;
    assign b_resp   = 2'b00;

    logic unused_in;
    assign unused_in = ^{ar_addr[31:3], ar_addr[1:0], ar_size, ar_burst, aw_addr[31:3], aw_addr[1:0],
                         aw_len, aw_size, aw_burst, w_data[31:8], w_strb[3:1]};
endmodule

// File: tb/tb_axi_uart_regs.sv
// Self-checking bench for axi_uart_regs: directed vector table plus hand sequences for
// TX backpressure, burst stalls, RX overrun and mid-transaction reset.
module tb_axi_uart_regs;
    logic        clk, rst_n;
    logic [7:0]  ar_id, aw_id, r_id, b_id;
    logic [31:0] ar_addr, aw_addr, r_data, w_data;
    logic [7:0]  ar_len, aw_len;
    logic [2:0]  ar_size, aw_size;
    logic [1:0]  ar_burst, aw_burst, r_resp, b_resp;
    logic        ar_valid, ar_ready, r_last, r_valid, r_ready;
    logic        aw_valid, aw_ready, w_last, w_valid, w_ready, b_valid, b_ready;
    logic [3:0]  w_strb;
    logic [7:0]  tx_data, rx_data;
    logic        tx_valid, tx_ready, rx_valid;

    int n_checks = 0;
    int n_fail   = 0;

    axi_uart_regs #(.TX_DEPTH(16), .RX_DEPTH(16), .ID_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
        .ar_valid(ar_valid), .ar_ready(ar_ready),
        .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last), .r_valid(r_valid), .r_ready(r_ready),
        .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
        .aw_valid(aw_valid), .aw_ready(aw_ready),
        .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready),
        .b_id(b_id), .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef enum logic [1:0] {OP_RX, OP_RD, OP_WR, OP_TX} op_e;
    typedef struct {
        op_e         op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

`ifdef UART_OVERRUN_EN
    localparam logic [31:0] OVF_STATUS = 32'h7;
`else
    localparam logic [31:0] OVF_STATUS = 32'h3;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic ar_phase(input logic [31:0] addr, input logic [7:0] id, input logic [7:0] len);
        int n = 0;
        @(negedge clk);
        ar_valid = 1'b1; ar_addr = addr; ar_id = id; ar_len = len;
        while (!ar_ready && n < 50) begin @(negedge clk); n++; end
        check("ar_ready_wait", ar_ready, 1);
        @(posedge clk);
        @(negedge clk);
        ar_valid = 1'b0;
    endtask

    task automatic wait_rvalid(input string name);
        int n = 0;
        while (!r_valid && n < 50) begin @(negedge clk); n++; end
        check(name, r_valid, 1);
    endtask

    task automatic read_single(input logic [31:0] addr, input logic [7:0] id, output logic [31:0] d);
        ar_phase(addr, id, 8'd0);
        wait_rvalid("r_valid_wait");
        check("r_resp_last_id", {r_resp, r_last, r_id}, {2'b00, 1'b1, id});
        d = r_data;
        r_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        r_ready = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        read_single(addr, 8'h33, d);
        check(name, d, exp);
    endtask

    task automatic aw_phase(input logic [31:0] addr, input logic [7:0] id);
        int n = 0;
        @(negedge clk);
        aw_valid = 1'b1; aw_addr = addr; aw_id = id; aw_len = 8'd0;
        while (!aw_ready && n < 50) begin @(negedge clk); n++; end
        check("aw_ready_wait", aw_ready, 1);
        @(posedge clk);
        @(negedge clk);
        aw_valid = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] data, input logic [3:0] strb);
        int n = 0;
        @(negedge clk);
        w_valid = 1'b1; w_data = data; w_strb = strb; w_last = 1'b1;
        while (!w_ready && n < 50) begin @(negedge clk); n++; end
        check("w_ready_wait", w_ready, 1);
        @(posedge clk);
        @(negedge clk);
        w_valid = 1'b0; w_last = 1'b0;
    endtask

    task automatic b_phase(input logic [7:0] id);
        int n = 0;
        b_ready = 1'b1;
        while (!b_valid && n < 50) begin @(negedge clk); n++; end
        check("b_valid_wait", b_valid, 1);
        check("b_resp_id", {b_resp, b_id}, {2'b00, id});
        @(posedge clk);
        @(negedge clk);
        b_ready = 1'b0;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        aw_phase(addr, 8'h60);
        w_beat(data, strb);
        b_phase(8'h60);
    endtask

    task automatic rx_strobe(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1; rx_data = b;
        @(posedge clk);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic [7:0]  exp_b;
        int k;

        vecs[0]  = '{OP_RX, 32'h0,  32'h55,        4'h0, 32'h0};
        vecs[1]  = '{OP_RD, 32'h4,  32'h0,         4'h0, 32'h3};
        vecs[2]  = '{OP_RD, 32'h0,  32'h0,         4'h0, 32'h55};
        vecs[3]  = '{OP_RD, 32'h4,  32'h0,         4'h0, 32'h1};
        vecs[4]  = '{OP_RD, 32'h0,  32'h0,         4'h0, 32'h0};
        vecs[5]  = '{OP_RD, 32'hC,  32'h0,         4'h0, 32'h1};
        vecs[6]  = '{OP_WR, 32'h0,  32'h99,        4'h0, 32'h0};
        vecs[7]  = '{OP_TX, 32'h0,  32'h0,         4'h0, 32'h0};
        vecs[8]  = '{OP_WR, 32'h4,  32'hFF,        4'h1, 32'h0};
        vecs[9]  = '{OP_TX, 32'h0,  32'h0,         4'h0, 32'h0};
        vecs[10] = '{OP_WR, 32'h10, 32'h123456C3,  4'h1, 32'h0};
        vecs[11] = '{OP_TX, 32'h0,  32'h0,         4'h0, 32'h1C3};
        vecs[12] = '{OP_RD, 32'h4,  32'h0,         4'h0, 32'h1};
        vecs[13] = '{OP_RX, 32'h0,  32'h80,        4'h0, 32'h0};
        vecs[14] = '{OP_RX, 32'h0,  32'h81,        4'h0, 32'h0};
        vecs[15] = '{OP_RD, 32'h8,  32'h0,         4'h0, 32'h80};
        vecs[16] = '{OP_RD, 32'h0,  32'h0,         4'h0, 32'h81};

        ar_valid = 0; ar_id = 0; ar_addr = 0; ar_len = 0; ar_size = 3'd2; ar_burst = 2'b01;
        aw_valid = 0; aw_id = 0; aw_addr = 0; aw_len = 0; aw_size = 3'd2; aw_burst = 2'b01;
        w_valid = 0; w_data = 0; w_strb = 0; w_last = 0;
        r_ready = 0; b_ready = 0; tx_ready = 1'b1; rx_valid = 0; rx_data = 0;

        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_ar_aw_ready", {ar_ready, aw_ready}, 2'b11);
        check("rst_valids", {r_valid, w_ready, b_valid, tx_valid}, 4'b0000);
        check("rst_r_data", r_data, 32'h0);
        check("rst_last_ids_resp", {r_last, r_id, b_id, r_resp, b_resp}, 21'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Single write: byte appears on tx the cycle after the W handshake.
        aw_phase(32'h0, 8'h3C);
        w_beat(32'h00000041, 4'b0001);
        check("t1_tx", {tx_valid, tx_data}, {1'b1, 8'h41});
        b_phase(8'h3C);

        // TX full backpressure.
        @(negedge clk);
        tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) axi_write(32'h0, 32'h10 + i, 4'b0001);
        read_check("t2_status_full", 32'h4, 32'h0);
        aw_phase(32'h0, 8'h61);
        w_valid = 1'b1; w_data = 32'h20; w_strb = 4'b0001; w_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("t2_w_ready_low", w_ready, 0);
            @(negedge clk);
        end
        check("t2_head", {tx_valid, tx_data}, {1'b1, 8'h10});
        tx_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_ready = 1'b0;
        check("t2_w_ready_high", w_ready, 1);
        @(posedge clk);
        @(negedge clk);
        w_valid = 1'b0; w_last = 1'b0;
        b_phase(8'h61);
        tx_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 100 && k < 16; c++) begin
            if (tx_valid) begin
                exp_b = (k < 15) ? 8'(8'h11 + k) : 8'h20;
                check($sformatf("t2_drain%0d", k), tx_data, exp_b);
                k++;
            end
            @(negedge clk);
        end
        check("t2_drain_count", k, 16);
        check("t2_tx_empty", tx_valid, 0);
        tx_ready = 1'b0;

        for (int i = 0; i < NV; i++) begin
            case (vecs[i].op)
                OP_RX: rx_strobe(vecs[i].data[7:0]);
                OP_WR: axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
                OP_TX: begin
                    @(negedge clk);
                    check($sformatf("vec%0d_tx", i), {tx_valid, tx_valid ? tx_data : 8'h0}, vecs[i].exp);
                end
                default: begin
                    read_single(vecs[i].addr, 8'(8'h40 + i), rd);
                    check($sformatf("vec%0d_rd", i), rd, vecs[i].exp);
                end
            endcase
        end

        // Burst read with r_ready stalls and an RX byte arriving mid-beat.
        rx_strobe(8'h11); rx_strobe(8'h22); rx_strobe(8'h33);
        ar_phase(32'h0, 8'h5A, 8'd2);
        for (int beat = 0; beat < 3; beat++) begin
            exp_b = (beat == 0) ? 8'h11 : (beat == 1) ? 8'h22 : 8'h33;
            wait_rvalid($sformatf("t4_rvalid%0d", beat));
            check($sformatf("t4_meta%0d", beat), {r_resp, r_last, r_id}, {2'b00, beat == 2, 8'h5A});
            check($sformatf("t4_data%0d", beat), r_data, {24'h0, exp_b});
            if (beat == 0) begin
                rx_valid = 1'b1; rx_data = 8'h44;
            end
            @(negedge clk);
            rx_valid = 1'b0;
            check($sformatf("t4_stall_a%0d", beat), {r_valid, r_data}, {1'b1, 24'h0, exp_b});
            @(negedge clk);
            check($sformatf("t4_stall_b%0d", beat), {r_valid, r_data}, {1'b1, 24'h0, exp_b});
            r_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            r_ready = 1'b0;
            if (beat < 2) check($sformatf("t4_bubble%0d", beat), r_valid, 0);
        end
        check("t4_ar_ready_back", ar_ready, 1);
        read_check("t4_late_byte", 32'h0, 32'h44);
        read_check("t4_status", 32'h4, 32'h1);

        // RX overrun: 17 strobes, the last one dropped.
        for (int i = 0; i < 17; i++) rx_strobe(8'(8'hA0 + i));
        read_check("t5_status_ovf", 32'h4, OVF_STATUS);
        read_check("t5_status_again", 32'h4, 32'h3);
        for (int i = 0; i < 16; i++) read_check($sformatf("t5_rx%0d", i), 32'h0, 32'hA0 + i);
        read_check("t5_status_empty", 32'h4, 32'h1);

        // Reset during a burst read and with a write response pending.
        rx_strobe(8'h66); rx_strobe(8'h77);
        aw_phase(32'h0, 8'h70);
        w_beat(32'h5A, 4'b0001);
        ar_phase(32'h0, 8'h21, 8'd3);
        wait_rvalid("t6_rvalid");
        check("t6_pre_reset", {b_valid, tx_valid}, 2'b11);
        rst_n = 1'b0;
        #1;
        check("t6_r_valid_rst", r_valid, 0);
        check("t6_b_valid_rst", b_valid, 0);
        check("t6_tx_valid_rst", tx_valid, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t6_ready_after", {ar_ready, aw_ready}, 2'b11);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6_no_stale_resp", {r_valid, b_valid, w_ready}, 3'b000);
        end
        read_check("t6_status", 32'h4, 32'h1);
        read_check("t6_rx_empty", 32'h0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
